// File: rtl/edge_sync_pkg.sv
// Shared definitions for the edge_sync_multi block.
// Contents:
//   edge_mode_t     - per-channel edge-detect mode encoding
//   SYNC_STAGES_MIN - smallest legal synchroniser depth
package edge_sync_pkg;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_t;

    localparam int unsigned SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/edge_sync_chan.sv
// One channel of edge_sync_multi: synchroniser chain, optional glitch filter,
// edge detector and sticky event flag.
// Optional feature: define EDGE_SYNC_FILT_EN to build the glitch filter.
// Ports:
//   clk       - clock, rising edge
//   rst_n     - asynchronous active-low reset
//   data      - asynchronous input
//   edge_mode - edge selection (edge_mode_t encoding)
//   evt_clr   - sticky flag clear
//   level_out - synchronised (filtered) level
//   pulse_out - one-cycle edge strobe
//   evt_flag  - sticky event flag
module edge_sync_chan
    import edge_sync_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       data,
    input  logic [1:0] edge_mode,
    input  logic       evt_clr,
    output logic       level_out,
    output logic       pulse_out,
    output logic       evt_flag
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sy;
    logic                   level_q, level_d;
    logic                   pulse_q, pulse_d;
    logic                   flag_q, flag_d;
    logic                   rise, fall;

    // Bit 0 samples the asynchronous input; the top bit is the synchronised sample.
    assign sync_d = {sync_q[SYNC_STAGES-2:0], data};
    assign sy     = sync_q[SYNC_STAGES-1];

`ifdef EDGE_SYNC_FILT_EN
    localparam int unsigned CntW = $clog2(FILT_LEN) + 1;

    logic [CntW-1:0] cnt_q, cnt_d;

    // Level only moves once sy has differed from it for FILT_LEN consecutive cycles.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sy == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntW'(FILT_LEN - 1)) begin
            level_d = sy;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    if (FILT_LEN < 1) begin : g_bad_filt
        $error("FILT_LEN must be at least 1");
    end

    assign level_d = sy;
`endif

    assign rise = level_d & ~level_q;
    assign fall = ~level_d & level_q;

    always_comb begin
        pulse_d = 1'b0;
        unique case (edge_mode_t'(edge_mode))
            EDGE_OFF:  pulse_d = 1'b0;
            EDGE_RISE: pulse_d = rise;
            EDGE_FALL: pulse_d = fall;
            EDGE_BOTH: pulse_d = rise | fall;
            default:   pulse_d = 1'b0;
        endcase
    end

    // Flag follows the registered pulse, so it rises one edge after pulse_out; set beats clear.
    assign flag_d = pulse_q | (flag_q & ~evt_clr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            flag_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
            flag_q  <= flag_d;
        end
    end

    assign level_out = level_q;
    assign pulse_out = pulse_q;
    assign evt_flag  = flag_q;

endmodule

// File: rtl/edge_sync_multi.sv
// Multi-channel synchroniser and edge detector. Generates WIDTH independent
// edge_sync_chan instances and ORs their sticky flags.
// Optional feature: define EDGE_SYNC_FILT_EN to build the per-channel glitch filter.
// Ports:
//   clk       - clock, rising edge
//   rst_n     - asynchronous active-low reset
//   data      - asynchronous inputs, one per channel
//   edge_mode - per-channel mode, bits [2i+1:2i]
//   evt_clr   - per-channel sticky flag clear
//   level_out - synchronised (filtered) levels
//   pulse_out - one-cycle edge strobes
//   evt_flag  - sticky event flags
//   evt_any   - OR of evt_flag
module edge_sync_multi
    import edge_sync_pkg::*;
#(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   data,
    input  logic [2*WIDTH-1:0] edge_mode,
    input  logic [WIDTH-1:0]   evt_clr,
    output logic [WIDTH-1:0]   level_out,
    output logic [WIDTH-1:0]   pulse_out,
    output logic [WIDTH-1:0]   evt_flag,
    output logic               evt_any
);

    if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_sync
        $error("SYNC_STAGES must be at least SYNC_STAGES_MIN");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("WIDTH must be at least 1");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        edge_sync_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_LEN    (FILT_LEN)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .data      (data[i]),
            .edge_mode (edge_mode[2*i +: 2]),
            .evt_clr   (evt_clr[i]),
            .level_out (level_out[i]),
            .pulse_out (pulse_out[i]),
            .evt_flag  (evt_flag[i])
        );
    end

    assign evt_any = |evt_flag;

endmodule

// File: tb/tb_edge_sync_multi.sv
// Scoreboard bench for edge_sync_multi (WIDTH=4, SYNC_STAGES=2, FILT_LEN=4).
// Stimulus pushes expected outputs tagged with a cycle number; the monitor pops
// and compares on the falling edge of that cycle and flags any unexpected pulse.
module tb_edge_sync_multi;

    localparam int unsigned SS = 2;
    localparam int unsigned FL = 4;
`ifdef EDGE_SYNC_FILT_EN
    localparam int LAT = SS + FL;
`else
    localparam int LAT = SS + 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] data;
    logic [7:0] edge_mode;
    logic [3:0] evt_clr;
    logic [3:0] level_out, pulse_out, evt_flag;
    logic       evt_any;

    typedef struct {
        int         cyc;
        logic [3:0] pulse;
        logic [3:0] level;
        logic [3:0] flag;
        logic       any;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc    = 0;
    int   tests  = 0;
    int   failed = 0;

    edge_sync_multi #(
        .WIDTH       (4),
        .SYNC_STAGES (SS),
        .FILT_LEN    (FL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data      (data),
        .edge_mode (edge_mode),
        .evt_clr   (evt_clr),
        .level_out (level_out),
        .pulse_out (pulse_out),
        .evt_flag  (evt_flag),
        .evt_any   (evt_any)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            failed++;
            $display("FAIL %s cyc=%0d actual=%b required=%b", name, cyc, act, exp_v);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            tests++;
            failed++;
            $display("FAIL stale_expect cyc=%0d actual=missed required=cyc %0d", cyc, e.cyc);
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            chk("pulse_out", pulse_out, e.pulse);
            chk("level_out", level_out, e.level);
            chk("evt_flag", evt_flag, e.flag);
            chk("evt_any", {3'b000, evt_any}, {3'b000, e.any});
        end else if (rst_n === 1'b1 && pulse_out !== 4'b0000) begin
            tests++;
            failed++;
            $display("FAIL unexpected_pulse cyc=%0d actual=%b required=0000", cyc, pulse_out);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic expect_at(input int off, input logic [3:0] p, input logic [3:0] l,
                             input logic [3:0] f);
        exp_t x;
        x.cyc   = cyc + off;
        x.pulse = p;
        x.level = l;
        x.flag  = f;
        x.any   = |f;
        sb.push_back(x);
    endtask

    initial begin
        rst_n     = 1'b1;
        data      = 4'hF;
        edge_mode = 8'b11_10_01_00;
        evt_clr   = 4'h0;
        #1 rst_n  = 1'b0;

        // Reset state, then data held high through release: rise on ch1/ch3.
        tick(2);
        expect_at(0, 4'b0000, 4'b0000, 4'b0000);
        rst_n = 1'b1;
        expect_at(LAT, 4'b1010, 4'hF, 4'b0000);
        expect_at(LAT + 1, 4'b0000, 4'hF, 4'b1010);
        tick(LAT + 2);

        evt_clr = 4'hF;
        tick(1);
        evt_clr = 4'h0;
        expect_at(0, 4'b0000, 4'hF, 4'b0000);

        // All fall together: fall on ch2/ch3.
        data = 4'h0;
        expect_at(LAT, 4'b1100, 4'h0, 4'b0000);
        expect_at(LAT + 1, 4'b0000, 4'h0, 4'b1100);
        tick(LAT + 2);
        evt_clr = 4'hF;
        tick(1);
        evt_clr = 4'h0;
        expect_at(0, 4'b0000, 4'h0, 4'b0000);

        // Rise again.
        data = 4'hF;
        expect_at(LAT, 4'b1010, 4'hF, 4'b0000);
        expect_at(LAT + 1, 4'b0000, 4'hF, 4'b1010);
        tick(LAT + 2);

        // Clear in the same cycle as the pulse that sets ch2: set wins.
        data = 4'h0;
        tick(LAT);
        expect_at(0, 4'b1100, 4'h0, 4'b1010);
        evt_clr = 4'b0100;
        tick(1);
        expect_at(0, 4'b0000, 4'h0, 4'b1110);
        tick(1);
        evt_clr = 4'h0;
        expect_at(0, 4'b0000, 4'h0, 4'b1010);
        evt_clr = 4'hF;
        tick(1);
        evt_clr = 4'h0;
        expect_at(0, 4'b0000, 4'h0, 4'b0000);

        // Mode change while level high must not pulse.
        data = 4'hF;
        expect_at(LAT, 4'b1010, 4'hF, 4'b0000);
        expect_at(LAT + 1, 4'b0000, 4'hF, 4'b1010);
        tick(LAT + 2);
        edge_mode = 8'b11_10_01_01;
        expect_at(2, 4'b0000, 4'hF, 4'b1010);
        tick(3);

        // ch1 and ch3 fall; only ch3 (both) pulses.
        data = 4'b0101;
        expect_at(LAT, 4'b1000, 4'b0101, 4'b1010);
        expect_at(LAT + 1, 4'b0000, 4'b0101, 4'b1010);
        tick(LAT + 2);

`ifdef EDGE_SYNC_FILT_EN
        // Two-cycle glitch on ch1 is filtered out.
        data = 4'b0111;
        tick(2);
        data = 4'b0101;
        expect_at(LAT + 2, 4'b0000, 4'b0101, 4'b1010);
        tick(LAT + 3);
`endif

        // Reset mid-transition clears everything; no pulse after release.
        data = 4'b0000;
        tick(1);
        rst_n = 1'b0;
        expect_at(0, 4'b0000, 4'b0000, 4'b0000);
        tick(2);
        rst_n = 1'b1;
        expect_at(LAT + 2, 4'b0000, 4'b0000, 4'b0000);
        tick(LAT + 3);

        // Fresh rise on ch0, now in rise mode.
        data = 4'b0001;
        expect_at(LAT, 4'b0001, 4'b0001, 4'b0000);
        expect_at(LAT + 1, 4'b0000, 4'b0001, 4'b0001);
        tick(LAT + 3);

        chk("sb_drained", 4'(sb.size()), 4'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/edge_sync_multi.md
# edge_sync_multi

Parametrised multi-channel synchroniser and edge detector. Each channel's asynchronous input passes through a SYNC_STAGES flop chain into a single clock domain. An optional glitch filter follows the chain. A per-channel, run-time-selectable edge detector then produces one-cycle pulses and sticky event flags. The block sits at the boundary between external or foreign-domain status lines and control logic that needs clean, single-cycle event strobes.

## Interface
- WIDTH, 4: number of independent channels (≥1)
- SYNC_STAGES, 2: synchroniser depth (≥2)
- FILT_LEN, 4: glitch-filter stability length in clk cycles (≥1; only used with filter compiled in)

- clk  in  1  single clock; all logic is rising-edge
- rst_n  in  1  asynchronous, active-low reset
- data  in  WIDTH  asynchronous inputs, one bit per channel
- edge_mode  in  2*WIDTH  per-channel mode, bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
- evt_clr  in  WIDTH  per-channel sticky-flag clear, synchronous to clk
- level_out  out  WIDTH  synchronised (filtered) level per channel
- pulse_out  out  WIDTH  one-cycle edge strobe per channel (registered)
- evt_flag  out  WIDTH  sticky event flags (registered)
- evt_any  out  1  OR of evt_flag (combinational)

## Operation
- Reset: all sync flops, level_out, pulse_out, evt_flag and filter counters are 0; evt_any is 0.
- Synchroniser: s[0] ← data[i]; s[k] ← s[k-1]; s[SYNC_STAGES-1] is the synchronised sample `sy`.
- Level without filter: level_out[i] ← sy each cycle.
- Level with filter:
  - Per-channel counter, width $clog2(FILT_LEN)+1.
  - If sy == level_out, the counter is set to 0.
  - Else if the counter == FILT_LEN-1, level_out ← sy and the counter is set to 0.
  - Else the counter increments.
- Edge detect: pulse_out[i] ← (level_next ≠ level_out) AND the mode selects that direction.
  - Rise is 0→1; fall is 1→0; both is either; off never pulses.
- level_out tracks the input regardless of edge_mode.
- A change in edge_mode affects only later level transitions and never creates a pulse by itself.
- Sticky flag: evt_flag[i] ← pulse_next[i] | (evt_flag[i] & ~evt_clr[i]). If a set and evt_clr occur in the same cycle, the set wins.
- Channels are fully independent. Simultaneous edges on several channels all pulse in the same cycle.
- An input held high through reset release yields a rising pulse after normal latency, because level_out resets to 0.
- Reset asserted mid-operation clears all state immediately. Partially filtered transitions are discarded.

## Timing
- Count edge 1 as the first clk edge that samples the new data value.
- Latency without filter: level_out and pulse_out change at edge SYNC_STAGES+1.
- Latency with filter: they change at edge SYNC_STAGES+FILT_LEN. FILT_LEN=1 gives the same timing as no filter.
- pulse_out is high for exactly one cycle per qualifying transition.
- evt_flag rises one edge after pulse_out rises.
- A filtered input pulse shorter than FILT_LEN stable synchronised cycles produces no level change and no pulse.
- Inputs must be held for at least SYNC_STAGES cycles to be guaranteed seen when the filter is compiled out.

## Configuration
- EDGE_SYNC_FILT_EN defined: glitch filter and counters are instantiated, with timing as above.
- EDGE_SYNC_FILT_EN undefined: no counters; level_out ← sy directly, and FILT_LEN is ignored.

## Structure
- Shared package edge_sync_pkg holds:
  - the 2-bit edge_mode_t with EDGE_OFF=2'b00, EDGE_RISE=2'b01, EDGE_FALL=2'b10, EDGE_BOTH=2'b11
  - the constant SYNC_STAGES_MIN=2
- Sub-module edge_sync_chan implements one channel: sync chain, filter, edge detect and flag. The top generates WIDTH instances and ORs the flags.

## Test plan
- Filter out, defaults, ch0 mode 01: data[0] 0→1 at edge 1 → pulse_out[0]=1 only in the cycle after edge 3, level_out[0]=1 from edge 3; evt_flag[0]=1 from edge 4.
- Filter in, FILT_LEN=4, ch1 mode 11: data[1] high for 2 cycles, then low → no level change, no pulse. Then high for 10 cycles → pulse at edge 6; on the fall, a second pulse 6 edges later.
- Mode check, 4 channels all toggled 0→1→0 together, edge_mode=8'b11_10_01_00 → ch0 never pulses; ch1 pulses on the rise only; ch2 on the fall only; ch3 on both. All level_out follow the input.
- evt_clr[2]=1 in the same cycle a pulse sets evt_flag[2] → flag stays 1. A later evt_clr alone → flag 0, and evt_any=0 once all flags are clear.
- data=4'hF held through reset release → after latency, a rising pulse on every channel in mode 01/11. Reset asserted mid-filter count → all outputs 0 immediately, with no pulse after release until a fresh stable transition.
- SYNC_STAGES=3, filter out → pulse at edge 4. Changing edge_mode from 00 to 01 while level_out=1 → no pulse.
